// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH-channel PWM with one shared period counter, a prescaler,
// edge- or center-aligned counting and double-buffered PERIOD/DUTY values,
// attached to the simple word-wide peripheral bus.
// Optional period-end flag and interrupt: define PWM_IRQ_EN.
module pwm_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [5:0]        mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [NUM_CH-1:0] pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  // Programmer-visible registers
  logic                   global_en;
  mode_t                  ctrl_mode;
  logic [NUM_CH-1:0]      ch_en;
  logic [CNT_WIDTH-1:0]   period_reg;
  logic [PRESC_WIDTH-1:0] presc_reg;
  logic [CNT_WIDTH-1:0]   duty_reg [NUM_CH];

  // Counter state and shadow copies used by the compare
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [CNT_WIDTH-1:0]   cnt;
  dir_t                   dir;
  mode_t                  active_mode;
  logic [CNT_WIDTH-1:0]   active_period;
  logic [CNT_WIDTH-1:0]   active_duty [NUM_CH];

  logic [3:0]           reg_idx;
  logic                 wr_en;
  logic                 ctrl_wr;
  mode_t                mode_next;
  logic [31:0]          rd_data;
  logic                 tick;
  logic                 boundary;
  logic [CNT_WIDTH-1:0] cnt_next;
  dir_t                 dir_next;
  logic                 unused_ok;

  assign reg_idx   = mem_addr[5:2];
  assign wr_en     = mem_valid & mem_we;
  assign ctrl_wr   = wr_en && (reg_idx == 4'd0);
  // Mode written together with the enable bit must already apply to the
  // first period, so the idle shadow load takes the incoming value.
  assign mode_next = ctrl_wr ? mode_t'(mem_wdata[1]) : ctrl_mode;
  assign unused_ok = ^{mem_addr[1:0], mem_wdata};

`ifdef PWM_IRQ_EN
  logic irq_en;
  logic status;
  logic status_clr;
  assign status_clr = wr_en && (reg_idx == 4'd3) && mem_wdata[0];
`endif

  // Register read multiplexer; unmapped offsets and unused bits read 0
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      4'd0: begin
        rd_data[0]           = global_en;
        rd_data[1]           = (ctrl_mode == MODE_CENTER);
`ifdef PWM_IRQ_EN
        rd_data[2]           = irq_en;
`endif
        rd_data[8 +: NUM_CH] = ch_en;
      end
      4'd1: rd_data[CNT_WIDTH-1:0]   = period_reg;
      4'd2: rd_data[PRESC_WIDTH-1:0] = presc_reg;
`ifdef PWM_IRQ_EN
      4'd3: rd_data[0]               = status;
`endif
      default: begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (reg_idx == 4'(i + 4)) rd_data[CNT_WIDTH-1:0] = duty_reg[i];
      end
    endcase
  end

  // Bus response and register writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      global_en  <= 1'b0;
      ctrl_mode  <= MODE_EDGE;
      ch_en      <= '0;
      period_reg <= '0;
      presc_reg  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_reg[i] <= '0;
`ifdef PWM_IRQ_EN
      irq_en     <= 1'b0;
`endif
    end else begin
      mem_ready <= mem_valid;
      mem_rdata <= (mem_valid && !mem_we) ? rd_data : '0;
      ctrl_mode <= mode_next;
      if (wr_en) begin
        case (reg_idx)
          4'd0: begin
            global_en <= mem_wdata[0];
            ch_en     <= mem_wdata[8 +: NUM_CH];
`ifdef PWM_IRQ_EN
            irq_en    <= mem_wdata[2];
`endif
          end
          4'd1: period_reg <= mem_wdata[CNT_WIDTH-1:0];
          4'd2: presc_reg  <= mem_wdata[PRESC_WIDTH-1:0];
          default: begin
            for (int unsigned i = 0; i < NUM_CH; i++)
              if (reg_idx == 4'(i + 4)) duty_reg[i] <= mem_wdata[CNT_WIDTH-1:0];
          end
        endcase
      end
    end
  end

  // Next counter value, direction and period boundary for the current tick.
  // Center mode folds "top reached" and "counting down" into one branch:
  // from either, a count of 1 (or 0 when PERIOD=0) ends the period.
  always_comb begin
    tick     = (presc_cnt >= presc_reg);
    cnt_next = cnt;
    dir_next = dir;
    boundary = 1'b0;
    if (tick) begin
      if (active_mode == MODE_EDGE) begin
        if (cnt >= active_period) begin
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else if (dir == DIR_UP && cnt < active_period) begin
        cnt_next = cnt + 1'b1;
      end else if (cnt <= CNT_WIDTH'(1)) begin
        cnt_next = '0;
        dir_next = DIR_UP;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt - 1'b1;
        dir_next = DIR_DOWN;
      end
    end
  end

  // Prescaler, period counter, shadow reload and registered compare outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt     <= '0;
      cnt           <= '0;
      dir           <= DIR_UP;
      active_mode   <= MODE_EDGE;
      active_period <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) active_duty[i] <= '0;
      pwm_out       <= '0;
    end else begin
      if (!global_en) begin
        presc_cnt     <= '0;
        cnt           <= '0;
        dir           <= DIR_UP;
        active_mode   <= mode_next;
        active_period <= period_reg;
        for (int unsigned i = 0; i < NUM_CH; i++) active_duty[i] <= duty_reg[i];
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        cnt       <= cnt_next;
        dir       <= dir_next;
        if (boundary) begin
          active_mode   <= ctrl_mode;
          active_period <= period_reg;
          for (int unsigned i = 0; i < NUM_CH; i++) active_duty[i] <= duty_reg[i];
        end
      end
      for (int unsigned i = 0; i < NUM_CH; i++)
        pwm_out[i] <= global_en & ch_en[i] & (cnt < active_duty[i]);
    end
  end

`ifdef PWM_IRQ_EN
  // Period-end flag (set beats clear) and registered interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (global_en && boundary) status <= 1'b1;
      else if (status_clr)       status <= 1'b0;
      irq <= status & irq_en;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: register table, PWM waveform table
// against a closed-form counter model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 8;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_PERIOD = 6'h04;
  localparam logic [5:0] A_PRESC  = 6'h08;
  localparam logic [5:0] A_STATUS = 6'h0C;
  localparam logic [5:0] A_DUTY0  = 6'h10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mem_valid;
  logic           mem_we;
  logic [5:0]     mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata;
  logic           mem_ready;
  logic [NCH-1:0] pwm_out;
`ifdef PWM_IRQ_EN
  logic           irq;
`endif

  pwm_multi #(.NUM_CH(NCH), .CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pwm_out(pwm_out)
`ifdef PWM_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bus response scoreboard
  typedef struct {
    logic [31:0] exp;
    bit          chk_data;
    int          due;
  } resp_t;
  resp_t sb[$];
  resp_t resp;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      resp = sb.pop_front();
      check("mem_ready", 32'(mem_ready), 32'd1);
      if (resp.chk_data) check("mem_rdata", mem_rdata, resp.exp);
    end else if (mem_ready === 1'b1) begin
      check("spurious_ready", 32'(mem_ready), 32'd0);
    end
  end

  // Called just after a rising edge; leaves the bus idle just after the next one
  task automatic bus_op(input bit we, input logic [5:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input bit chk_data);
    resp_t r;
    mem_valid = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = data;
    r.exp = exp; r.chk_data = chk_data; r.due = cyc + 1;
    sb.push_back(r);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    bus_op(1'b1, addr, data, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp);
    bus_op(1'b0, addr, 32'h0, exp, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Register table
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t rv [9];

  // Waveform table
  typedef struct {
    bit                     center;
    int                     period;
    int                     presc;
    logic [NCH-1:0][CW-1:0] duty;
    logic [NCH-1:0]         en;
    int                     ncyc;
  } wave_t;
  wave_t waves [7];

  function automatic wave_t mkw(input bit c, input int p, input int ps,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic [NCH-1:0] en, input int n);
    wave_t w;
    w.center = c; w.period = p; w.presc = ps;
    w.duty[0] = CW'(d0); w.duty[1] = CW'(d1); w.duty[2] = CW'(d2); w.duty[3] = CW'(d3);
    w.en = en; w.ncyc = n;
    return w;
  endfunction

  // Expected outputs k cycles after the enabling write completed
  function automatic logic [NCH-1:0] model_pwm(input wave_t w, input int k);
    logic [NCH-1:0] r;
    int t, c, tm;
    r = '0;
    if (k == 0) return r;
    t = (k - 1) / (w.presc + 1);
    if (!w.center) c = t % (w.period + 1);
    else if (w.period == 0) c = 0;
    else begin
      tm = t % (2 * w.period);
      c  = (tm <= w.period) ? tm : 2 * w.period - tm;
    end
    for (int ch = 0; ch < NCH; ch++) r[ch] = w.en[ch] && (c < int'(w.duty[ch]));
    return r;
  endfunction

  task automatic run_wave(input int idx);
    wave_t w;
    logic [31:0] ctrl;
    w = waves[idx];
    wr(A_CTRL, 32'h0);
    wr(A_PERIOD, 32'(w.period));
    wr(A_PRESC, 32'(w.presc));
    for (int ch = 0; ch < NCH; ch++) wr(A_DUTY0 + 6'(4 * ch), 32'(w.duty[ch]));
    ctrl = (32'(w.en) << 8) | (w.center ? 32'h2 : 32'h0) | 32'h1;
    wr(A_CTRL, ctrl);
    for (int k = 0; k < w.ncyc; k++) begin
      @(negedge clk);
      check($sformatf("wave%0d_k%0d", idx, k), 32'(pwm_out), 32'(model_pwm(w, k)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rv[0] = '{A_PERIOD, 32'h0000_1234, 32'h0000_1234};
    rv[1] = '{A_PERIOD, 32'hFFFF_ABCD, 32'h0000_ABCD};
    rv[2] = '{A_PRESC,  32'h0000_01FF, 32'h0000_00FF};
    rv[3] = '{A_DUTY0,  32'h0001_0005, 32'h0000_0005};
    rv[4] = '{6'h1C,    32'h0005_A5A5, 32'h0000_A5A5};
    rv[5] = '{6'h20,    32'hDEAD_BEEF, 32'h0000_0000};
    rv[6] = '{6'h3C,    32'hFFFF_FFFF, 32'h0000_0000};
    rv[7] = '{A_STATUS, 32'h0000_0001, 32'h0000_0000};
`ifdef PWM_IRQ_EN
    rv[8] = '{A_CTRL,   32'hFFFF_FFFE, 32'h0000_0F06};
`else
    rv[8] = '{A_CTRL,   32'hFFFF_FFFE, 32'h0000_0F02};
`endif

    waves[0] = mkw(1'b0, 9, 0, 3,  5, 0, 0, 4'b0001, 40);
    waves[1] = mkw(1'b1, 4, 0, 0,  2, 0, 0, 4'b0010, 32);
    waves[2] = mkw(1'b0, 9, 0, 0,  0, 0, 0, 4'b0001, 24);
    waves[3] = mkw(1'b0, 9, 0, 10, 0, 0, 0, 4'b0001, 24);
    waves[4] = mkw(1'b0, 9, 1, 3,  0, 0, 0, 4'b0001, 44);
    waves[5] = mkw(1'b1, 0, 0, 1,  0, 0, 0, 4'b0001, 12);
    waves[6] = mkw(1'b0, 5, 0, 1,  2, 6, 0, 4'b1111, 24);

    rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'h0);
    check("reset_mem_ready", 32'(mem_ready), 32'h0);
    check("reset_mem_rdata", mem_rdata, 32'h0);
`ifdef PWM_IRQ_EN
    check("reset_irq", 32'(irq), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    rd(A_CTRL, 32'h0);
    rd(A_PERIOD, 32'h0);
    rd(A_PRESC, 32'h0);
    rd(A_DUTY0, 32'h0);

    // Write then read back, issued on consecutive cycles
    foreach (rv[i]) begin
      wr(rv[i].addr, rv[i].wdata);
      rd(rv[i].addr, rv[i].exp);
    end

    foreach (waves[i]) run_wave(i);

    // Disabling channel 0 while running leaves the counter (and ch2) untouched
    wr(A_CTRL, 32'h0000_0E01);
    step(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ch0_disabled", 32'(pwm_out[0]), 32'h0);
      check("ch2_unaffected", 32'(pwm_out[2]), 32'h1);
    end
    @(posedge clk); #1;

    // Duty change mid-period applies from the next period
    wr(A_CTRL, 32'h0);
    wr(A_PERIOD, 32'd9);
    wr(A_PRESC, 32'd0);
    wr(A_DUTY0, 32'd3);
    wr(A_CTRL, 32'h0000_0101);
    step(2);
    wr(A_DUTY0, 32'd7);
    for (int k = 3; k < 33; k++) begin
      int j, d;
      @(negedge clk);
      j = k - 1;
      d = (j < 10) ? 3 : 7;
      check($sformatf("shadow_k%0d", k), 32'(pwm_out[0]), ((j % 10) < d) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1;

    // Reset while the output is high
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_pwm_out", 32'(pwm_out), 32'h0);
    check("midrst_mem_ready", 32'(mem_ready), 32'h0);
    @(posedge clk); #1;
    rd(A_CTRL, 32'h0);
    rd(A_PERIOD, 32'h0);
    rd(A_DUTY0, 32'h0);
    @(negedge clk);
    check("midrst_pwm_idle", 32'(pwm_out), 32'h0);
    @(posedge clk); #1;

`ifdef PWM_IRQ_EN
    wr(A_CTRL, 32'h0);
    wr(A_PERIOD, 32'd3);
    wr(A_DUTY0, 32'd2);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h0000_0105);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("irq_rise_k%0d", k), 32'(irq), (k >= 5) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1;
    wr(A_STATUS, 32'h1);
    @(negedge clk);
    check("irq_before_clear", 32'(irq), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_next_wrap", 32'(irq), 32'h1);
    @(posedge clk); #1;
    step(1);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h1);
    @(negedge clk);
    check("irq_set_wins", 32'(irq), 32'h1);
    @(posedge clk); #1;
`endif

    wr(A_CTRL, 32'h0);
    step(3);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM peripheral that supersedes the fixed two-output PWM on the SoC's uo_out[7:6]. It provides NUM_CH channels sharing one period counter, with a prescaler and edge- or center-aligned modes. Period and duty values are double-buffered, so writes take effect only at a period boundary. It attaches to the SoC's simple word-wide peripheral bus.

Parameters:
NUM_CH, 4, number of PWM channels (1..8)
CNT_WIDTH, 16, width of the counter, PERIOD and DUTY registers (2..32)
PRESC_WIDTH, 8, width of the prescaler register

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
mem_valid  in  1  bus request, single-cycle pulse
mem_we  in  1  1 = write, 0 = read; qualified by mem_valid
mem_addr  in  6  byte address; bits [5:2] select the register
mem_wdata  in  32  write data; full-word writes only
mem_rdata  out  32  read data; valid while mem_ready is high
mem_ready  out  1  one-cycle response pulse
pwm_out  out  NUM_CH  PWM outputs, registered
irq  out  1  period-end interrupt (present only with the optional feature)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low on rst_n.
- Reset values: all registers 0; counter 0; direction up; pwm_out 0; mem_ready 0; mem_rdata 0; irq 0.
- Register map (offset):
  - 0x00 CTRL: [0] global enable, [1] mode (0 = edge, 1 = center), [2] irq enable, [8+i] channel i enable.
  - 0x04 PERIOD[CNT_WIDTH-1:0].
  - 0x08 PRESCALE[PRESC_WIDTH-1:0].
  - 0x0C STATUS: [0] period-end flag, write-1-to-clear.
  - 0x10+4*i DUTY[i].
- Unmapped or unimplemented reads return 0; writes to them are ignored. Unused register bits read 0.
- Bus timing: a request in cycle N produces mem_ready=1 in cycle N+1 only. Write data is committed at the end of cycle N. mem_rdata carries the register value sampled in cycle N. A back-to-back mem_valid is accepted every cycle.
- Prescaler: presc_cnt counts 0..PRESCALE and then wraps. tick=1 in the cycle presc_cnt==PRESCALE. PRESCALE=0 gives tick=1 every cycle.
- Edge mode:
  - On each tick the counter advances 0,1,...,PERIOD,0,...
  - The boundary is the tick on which the counter wraps PERIOD->0.
  - Period is PERIOD+1 ticks.
- Center mode:
  - On each tick the counter runs 0 up to PERIOD, then PERIOD-1 down to 1, then 0.
  - The boundary is the tick on which the counter moves 1->0.
  - Period is 2*PERIOD ticks; PERIOD=0 holds the counter at 0 with a boundary every tick.
- Double-buffering: active_period and active_duty[i] load from the written registers on every boundary tick. While the global enable is 0 they load every cycle.
- Compare: pwm_out[i] is registered as (global_en & ch_en[i] & (cnt < active_duty[i])). It updates on the clock edge after the counter value.
  - DUTY=0 gives an output that is always low.
  - DUTY > max counter value gives an output that is always high.
  - The compare is unsigned, at CNT_WIDTH bits.
- Global enable=0: the counter and presc_cnt are held at 0, direction is up, and all pwm_out are 0 on the next edge. On 0->1 the counter starts at 0 and the first tick follows PRESCALE+1 cycles later.
- A channel enable of 0 forces that output low on the next edge without disturbing the counter.
- Mode change while running: takes effect at the next boundary. The counter restarts at 0 with direction up.
- Reset asserted mid-period: all state returns to its reset values on that edge; there are no partial outputs.

Optional Feature:
- Macro: PWM_IRQ_EN.
- Defined:
  - STATUS[0] is set on every boundary tick while enabled.
  - A write of 1 clears it; set wins over a simultaneous clear.
  - irq = STATUS[0] & CTRL[2], registered.
- Undefined: the irq port is absent, STATUS reads 0, CTRL[2] reads 0, and no flag logic is synthesised.

Test Plan:
- Edge: PERIOD=9, PRESCALE=0, DUTY0=3, CTRL=0x101 -> pwm_out[0] repeats 3 cycles high, 7 low; other channels stay 0.
- Center: PERIOD=4, DUTY1=2, CTRL=0x203 -> 8-cycle period; pwm_out[1] is high 3 consecutive cycles (cnt 1,0,1) and low 5.
- Shadow: edge PERIOD=9, DUTY0=3; write DUTY0=7 at cnt=2 -> the current period still shows 3 high; the next period shows 7 high.
- Limits: DUTY0=0 -> constant 0; DUTY0=10 with PERIOD=9 -> constant 1; PRESCALE=1 -> each counter step lasts 2 cycles (20-cycle period).
- Bus/reset: read 0x04 after writing 0x1234 -> mem_rdata=0x1234 with mem_ready one cycle later; read 0x3C -> 0; assert rst_n=0 mid-period -> pwm_out=0 and registers 0 on the next edge.
- PWM_IRQ_EN: CTRL=0x105, PERIOD=3 -> irq rises on each wrap; writing 1 to STATUS clears it; a clear coinciding with a boundary leaves the flag set.
